// File: rtl/pe_window_mac.sv
// pe_window_mac -- windowed 1-D convolution processing element.
//
// Streams signed activations into a shift buffer, then spends K cycles
// (K = 3 or 5 taps) accumulating WINDOW parallel dot products. Each window
// is presented as one wide psum_data word under a valid/ready handshake.
// The last K-1 activations of a window are reused by the next one, so only
// the first window of a job needs WINDOW+K-1 activations.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, kernel_mode    begin a job; 0 = 3 taps, 1 = 5 taps
//   num_windows           windows per job (0 = immediate done)
//   wt_in                 KMAX signed taps, tap k at [k*BIT_WIDTH +: BIT_WIDTH]
//   act_valid/ready/data  activation stream (accepted only while filling)
//   psum_valid/ready/data WINDOW results, lane i at [i*PSUM_WIDTH +: PSUM_WIDTH]
//   flush                 synchronous abort back to IDLE
//   busy, done            not idle; one-cycle end-of-job pulse
//
// Build option: define PE_WINDOW_RELU_EN to clamp each lane at zero on the
// output and to saturate accumulation instead of wrapping.

module pe_window_mac_lane #(
  parameter int BW = 8,
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [BW-1:0] w_i,
  input  logic [BW-1:0] a_i,
  output logic [PW-1:0] psum_o
);
  logic signed [2*BW-1:0] prod;
  logic signed [PW-1:0]   prod_x, sum, acc_q, acc_d;

  always_comb begin
    prod   = $signed(w_i) * $signed(a_i);
    prod_x = {{(PW-2*BW){prod[2*BW-1]}}, prod};
    sum    = acc_q + prod_x;
    acc_d  = sum;
`ifdef PE_WINDOW_RELU_EN
    // Same-sign operands producing an opposite-sign sum means overflow.
    if (!acc_q[PW-1] && !prod_x[PW-1] && sum[PW-1])
      acc_d = {1'b0, {(PW-1){1'b1}}};
    else if (acc_q[PW-1] && prod_x[PW-1] && !sum[PW-1])
      acc_d = {1'b1, {(PW-1){1'b0}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= acc_d;
  end

`ifdef PE_WINDOW_RELU_EN
  assign psum_o = acc_q[PW-1] ? '0 : acc_q;
`else
  assign psum_o = acc_q;
`endif
endmodule

module pe_window_mac #(
  parameter int BIT_WIDTH  = 8,
  parameter int WINDOW     = 6,
  parameter int PSUM_WIDTH = 32,
  parameter int KMAX       = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         kernel_mode,
  input  logic [15:0]                  num_windows,
  input  logic [KMAX*BIT_WIDTH-1:0]    wt_in,
  input  logic                         act_valid,
  output logic                         act_ready,
  input  logic [BIT_WIDTH-1:0]         act_data,
  output logic                         psum_valid,
  input  logic                         psum_ready,
  output logic [WINDOW*PSUM_WIDTH-1:0] psum_data,
  input  logic                         flush,
  output logic                         busy,
  output logic                         done
);
  localparam int NBUF = WINDOW + KMAX - 1;
  localparam int IW   = $clog2(NBUF);
  localparam int KW   = $clog2(KMAX);
  localparam int FW   = $clog2(NBUF + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMPUTE, S_OUT} state_e;
  state_e state_q, state_d;

  logic                              k5_q;
  logic [15:0]                       nwin_q, win_cnt_q;
  logic [KMAX-1:0][BIT_WIDTH-1:0]    wt_q;
  logic [NBUF-1:0][BIT_WIDTH-1:0]    abuf_q;   // newest entry at NBUF-1
  logic [FW-1:0]                     fill_cnt_q, need;
  logic [KW-1:0]                     tap_q;
  logic                              done_q;
  logic                              acc_take, fill_last, k_last, hs, win_last;
  logic                              lane_clr, lane_en;
  logic [IW-1:0]                     off;

  assign acc_take = act_valid && act_ready;
  assign hs       = psum_valid && psum_ready;
  assign win_last = (win_cnt_q + 16'd1) == nwin_q;
  assign k_last   = tap_q == (k5_q ? KW'(4) : KW'(2));
  // Fewer taps leave the oldest buffer slots unused; skip past them.
  assign off      = IW'(k5_q ? KMAX - 5 : KMAX - 3);

  always_comb begin
    need = FW'(WINDOW);
    if (win_cnt_q == 16'd0) need = k5_q ? FW'(WINDOW + 4) : FW'(WINDOW + 2);
  end
  assign fill_last = acc_take && (fill_cnt_q == FW'(need - FW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    act_ready  = state_q == S_FILL;
    psum_valid = state_q == S_OUT;
    busy       = state_q != S_IDLE;
    if (flush) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:    if (start && num_windows != 16'd0) state_d = S_FILL;
        S_FILL:    if (fill_last) state_d = S_COMPUTE;
        S_COMPUTE: if (k_last) state_d = S_OUT;
        S_OUT:     if (hs) state_d = win_last ? S_IDLE : S_FILL;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k5_q <= 1'b0; nwin_q <= '0; win_cnt_q <= '0; wt_q <= '0;
      abuf_q <= '0; fill_cnt_q <= '0; tap_q <= '0; done_q <= 1'b0;
    end else if (flush) begin
      win_cnt_q <= '0; abuf_q <= '0; fill_cnt_q <= '0; tap_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          k5_q      <= kernel_mode;
          wt_q      <= wt_in;
          nwin_q    <= num_windows;
          win_cnt_q <= '0;
          fill_cnt_q <= '0;
          done_q    <= num_windows == 16'd0;
        end
        S_FILL: if (acc_take) begin
          abuf_q     <= {act_data, abuf_q[NBUF-1:1]};
          fill_cnt_q <= fill_last ? '0 : fill_cnt_q + FW'(1);
          tap_q      <= '0;
        end
        S_COMPUTE: tap_q <= k_last ? '0 : tap_q + KW'(1);
        S_OUT: if (hs) begin
          win_cnt_q <= win_cnt_q + 16'd1;
          done_q    <= win_last;
        end
        default: ;
      endcase
    end
  end

  assign done     = done_q;
  assign lane_clr = flush || (state_q == S_FILL && fill_last);
  assign lane_en  = state_q == S_COMPUTE;

  for (genvar i = 0; i < WINDOW; i++) begin : g_lane
    logic [IW-1:0] idx;
    assign idx = IW'(i) + IW'(tap_q) + off;
    pe_window_mac_lane #(.BW(BIT_WIDTH), .PW(PSUM_WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (lane_clr),
      .en_i   (lane_en),
      .w_i    (wt_q[tap_q]),
      .a_i    (abuf_q[idx]),
      .psum_o (psum_data[i*PSUM_WIDTH +: PSUM_WIDTH])
    );
  end
endmodule

// File: tb/tb_pe_window_mac.sv
// Bench for pe_window_mac: table of jobs driven through a scoreboard,
// plus hand-written sequences for stall, flush, zero windows and reset.
module tb_pe_window_mac;
  localparam int BW = 8, WIN = 6, PW = 32, KM = 5;

  logic clk = 1'b0;
  logic rst_n, start, kernel_mode, act_valid, act_ready, psum_valid, psum_ready;
  logic flush, busy, done;
  logic [15:0] num_windows;
  logic [KM*BW-1:0] wt_in;
  logic [BW-1:0] act_data;
  logic [WIN*PW-1:0] psum_data;

  always #5 clk = ~clk;

  pe_window_mac #(.BIT_WIDTH(BW), .WINDOW(WIN), .PSUM_WIDTH(PW), .KMAX(KM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_mode(kernel_mode),
    .num_windows(num_windows), .wt_in(wt_in), .act_valid(act_valid),
    .act_ready(act_ready), .act_data(act_data), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .psum_data(psum_data), .flush(flush),
    .busy(busy), .done(done)
  );

  typedef struct {int kmode; int w[5]; int abase; int astep; int nwin; bit has0; int exp0;} vec_rec_t;
  typedef struct {logic [WIN*PW-1:0] v; bit has0; int exp0;} exp_t;

  vec_rec_t tbl[6];
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_acc = 0, cur_k = 3;
  bit hold_ready = 1'b0, prev_valid = 1'b0;

  task automatic chk(input bit ok, input string nm, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", nm, detail);
    end
  endtask

  task automatic set_rec(input int c, input int km, input int w0, input int w1, input int w2,
                         input int w3, input int w4, input int ab, input int as,
                         input int nw, input bit h0, input int e0);
    tbl[c].kmode = km;
    tbl[c].w[0] = w0; tbl[c].w[1] = w1; tbl[c].w[2] = w2; tbl[c].w[3] = w3; tbl[c].w[4] = w4;
    tbl[c].abase = ab; tbl[c].astep = as; tbl[c].nwin = nw; tbl[c].has0 = h0; tbl[c].exp0 = e0;
  endtask

  function automatic int kof(input int c);
    return tbl[c].kmode != 0 ? 5 : 3;
  endfunction

  function automatic int actv(input int c, input int j);
    logic signed [7:0] t;
    t = 8'(tbl[c].abase + j * tbl[c].astep);
    return int'(t);
  endfunction

  function automatic int wv(input int c, input int k);
    logic signed [7:0] t;
    t = 8'(tbl[c].w[k]);
    return int'(t);
  endfunction

  // Cycle counter and the cycle of the most recent activation accept.
  always @(posedge clk) begin
    if (act_valid && act_ready) last_acc <= cyc;
    cyc <= cyc + 1;
  end

  // Output side: drives psum_ready, checks latency and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    psum_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (psum_valid && !prev_valid)
      chk(cyc - last_acc == cur_k + 1, "psum_latency",
          $sformatf("got %0d cycles, want %0d", cyc - last_acc, cur_k + 1));
    prev_valid = psum_valid;
    if (psum_valid && psum_ready && !flush) begin
      if (exp_q.size() == 0) chk(1'b0, "unexpected_psum", $sformatf("got %h, none expected", psum_data));
      else begin
        e = exp_q.pop_front();
        chk(psum_data == e.v, "psum_vector", $sformatf("got %h want %h", psum_data, e.v));
        if (e.has0)
          chk($signed(psum_data[PW-1:0]) == e.exp0, "psum_lane0",
              $sformatf("got %0d want %0d", $signed(psum_data[PW-1:0]), e.exp0));
      end
    end
  end

  task automatic start_job(input int c);
    exp_t e;
    int s;
    @(negedge clk);
    kernel_mode = tbl[c].kmode[0];
    for (int k = 0; k < KM; k++) wt_in[k*BW +: BW] = 8'(tbl[c].w[k]);
    num_windows = 16'(tbl[c].nwin);
    start = 1'b1;
    cur_k = kof(c);
    for (int n = 0; n < tbl[c].nwin; n++) begin
      e.v = '0;
      for (int i = 0; i < WIN; i++) begin
        s = 0;
        for (int k = 0; k < kof(c); k++) s += wv(c, k) * actv(c, n*WIN + i + k);
`ifdef PE_WINDOW_RELU_EN
        if (s < 0) s = 0;
`endif
        e.v[i*PW +: PW] = 32'(s);
      end
      e.has0 = tbl[c].has0 && n == 0;
      e.exp0 = tbl[c].exp0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk(busy == 1'b1, "busy_after_start", $sformatf("got %0b want 1", busy));
  endtask

  task automatic drive_acts(input int c, input int n, input bit gaps);
    int idx = 0, guard = 0;
    while (idx < n && guard < 1000) begin
      @(negedge clk);
      act_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      act_data = 8'(actv(c, idx));
      if (act_valid && act_ready) idx++;
      guard++;
    end
    if (idx < n) chk(1'b0, "act_timeout", $sformatf("got %0d accepts want %0d", idx, n));
    @(negedge clk);
    act_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk(done === 1'b1, "done_pulse", $sformatf("got %0b want 1", done));
    chk(busy == 1'b0, "idle_after_done", $sformatf("busy %0b want 0", busy));
    chk(exp_q.size() == 0, "all_outputs", $sformatf("%0d outputs missing, want 0", exp_q.size()));
  endtask

  task automatic run_job(input int c, input bit gaps);
    start_job(c);
    drive_acts(c, WIN + kof(c) - 1 + (tbl[c].nwin - 1) * WIN, gaps);
    wait_done();
  endtask

  initial begin
    logic [WIN*PW-1:0] snap;
    int g;
    bit seen;
    rst_n = 1'b0; start = 1'b0; kernel_mode = 1'b0; num_windows = '0; wt_in = '0;
    act_valid = 1'b0; act_data = '0; flush = 1'b0;

    set_rec(0, 0, 1, 2, 3, 0, 0, 1, 1, 1, 1'b1, 14);
    set_rec(1, 0, 1, 2, 3, 0, 0, 1, 1, 2, 1'b1, 14);
    set_rec(2, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1'b1, 5);
`ifdef PE_WINDOW_RELU_EN
    set_rec(3, 0, -1, 0, 0, 0, 0, 5, 0, 1, 1'b1, 0);
`else
    set_rec(3, 0, -1, 0, 0, 0, 0, 5, 0, 1, 1'b1, -5);
`endif
    set_rec(4, 1, -3, 7, 2, -128, 127, -100, 37, 3, 1'b0, 0);
    set_rec(5, 0, 127, -128, 5, 99, -7, 3, -29, 2, 1'b0, 0);

    repeat (2) @(negedge clk);
    chk(act_ready == 1'b0, "rst_act_ready", $sformatf("got %0b want 0", act_ready));
    chk(psum_valid == 1'b0, "rst_psum_valid", $sformatf("got %0b want 0", psum_valid));
    chk(busy == 1'b0 && done == 1'b0, "rst_busy_done", $sformatf("got %0b/%0b want 0/0", busy, done));
    chk(psum_data == '0, "rst_psum_data", $sformatf("got %h want 0", psum_data));
    rst_n = 1'b1;
    @(negedge clk);

    for (int c = 0; c < 6; c++) run_job(c, c[0]);

    // Output stall: data must hold and no activations may be taken.
    hold_ready = 1'b1;
    start_job(0);
    drive_acts(0, 8, 1'b0);
    g = 0;
    while (!psum_valid && g < 50) begin @(negedge clk); g++; end
    chk(psum_valid == 1'b1, "stall_valid_seen", $sformatf("got %0b want 1", psum_valid));
    snap = psum_data;
    chk($signed(snap[0 +: PW]) == 14 && $signed(snap[5*PW +: PW]) == 44, "stall_lanes",
        $sformatf("got %0d,%0d want 14,44", $signed(snap[0 +: PW]), $signed(snap[5*PW +: PW])));
    repeat (3) begin
      @(negedge clk);
      chk(psum_valid && psum_data == snap, "stall_hold", $sformatf("got %h want %h", psum_data, snap));
      chk(act_ready == 1'b0, "stall_act_ready", $sformatf("got %0b want 0", act_ready));
    end
    hold_ready = 1'b0;
    wait_done();

    // Zero windows: done one cycle after start, never busy.
    @(negedge clk);
    num_windows = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk(done == 1'b1 && busy == 1'b0, "zero_win_done", $sformatf("done %0b busy %0b want 1/0", done, busy));
    @(negedge clk);
    chk(done == 1'b0, "zero_win_pulse", $sformatf("got %0b want 0", done));

    // Flush mid-fill with a coincident activation.
    start_job(0);
    drive_acts(0, 4, 1'b0);
    flush = 1'b1; act_valid = 1'b1; act_data = 8'd99;
    @(negedge clk);
    flush = 1'b0; act_valid = 1'b0;
    chk(!busy && !act_ready && !psum_valid && !done, "flush_idle",
        $sformatf("busy %0b ready %0b valid %0b done %0b want 0000", busy, act_ready, psum_valid, done));
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (psum_valid || done) seen = 1'b1; end
    chk(!seen, "flush_quiet", $sformatf("output seen %0b want 0", seen));
    exp_q.delete();
    run_job(0, 1'b0);

    // Reset in the middle of a job.
    start_job(1);
    drive_acts(1, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk(!busy && !act_ready && !psum_valid && psum_data == '0, "midjob_reset",
        $sformatf("busy %0b ready %0b valid %0b data %h want all 0", busy, act_ready, psum_valid, psum_data));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (busy || psum_valid || done) seen = 1'b1; end
    chk(!seen, "reset_stays_idle", $sformatf("activity %0b want 0", seen));
    run_job(1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_window_mac.md
PE_WINDOW_MAC -- requirements
Module: pe_window_mac

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, signed activation/weight width.
REQ-002 SHALL have parameter WINDOW, default 6, outputs per processing window (generalises the fixed six-state PE).
REQ-003 SHALL have parameter PSUM_WIDTH, default 32, accumulator width.
REQ-004 SHALL have parameter KMAX, default 5, maximum kernel taps.
REQ-005 SHALL have ports: clk in 1, the single clock; rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: start in 1, begin job; kernel_mode in 1, 0=3 taps, 1=5 taps; num_windows in 16, windows per job.
REQ-007 SHALL have port: wt_in in KMAX*BIT_WIDTH, signed taps, tap k at bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-008 SHALL have ports: act_valid in 1; act_ready out 1; act_data in BIT_WIDTH, signed activation.
REQ-009 SHALL have ports: psum_valid out 1; psum_ready in 1; psum_data out WINDOW*PSUM_WIDTH, output i at [i*PSUM_WIDTH +: PSUM_WIDTH].
REQ-010 SHALL have ports: flush in 1, synchronous abort; busy out 1; done out 1, one-cycle pulse.

Function
REQ-011 SHALL implement states IDLE, FILL, COMPUTE, OUT; busy=1 in all states except IDLE.
REQ-012 In IDLE, start=1 SHALL latch kernel_mode (K=3 or 5), wt_in and num_windows; start outside IDLE SHALL be ignored.
REQ-013 start with num_windows=0 SHALL stay in IDLE and pulse done on the next cycle.
REQ-014 Otherwise IDLE->FILL; the first window needs WINDOW+K-1 accepted activations, later windows need WINDOW, retaining the last K-1 activations of the previous window.
REQ-015 act_ready SHALL be 1 only in FILL; an activation is accepted when act_valid&act_ready; accepted values shift into a buffer of WINDOW+KMAX-1 entries.
REQ-016 On the cycle the final required activation is accepted, FILL->COMPUTE; accumulators SHALL be cleared on entry.
REQ-017 COMPUTE SHALL last exactly K cycles; in cycle k, acc[i] += w[k]*a[i+k] for all i in 0..WINDOW-1 in parallel, products sign-extended to PSUM_WIDTH, sums wrap modulo 2^PSUM_WIDTH.
REQ-018 COMPUTE->OUT after cycle K-1; psum_valid SHALL be asserted K+1 cycles after the last activation accept.
REQ-019 In OUT, psum_data SHALL hold stable while psum_valid=1 and psum_ready=0.
REQ-020 On psum_valid&psum_ready the window counter SHALL increment; if it equals num_windows, done pulses and the block returns to IDLE, otherwise it returns to FILL.
REQ-021 flush=1 in any state SHALL return to IDLE next cycle, clear the counter, buffer and accumulators, and drive psum_valid=0; flush SHALL win over a simultaneous psum handshake, with no done pulse.
REQ-022 flush coincident with an activation accept SHALL discard that activation.

Reset
REQ-023 rst_n=0 SHALL asynchronously force: state IDLE, act_ready=0, psum_valid=0, psum_data=0, busy=0, done=0, counter, buffer and accumulators 0.
REQ-024 Release of rst_n mid-job SHALL leave the block in IDLE awaiting start; no output is produced for the aborted job.

Configuration
REQ-025 Macro PE_WINDOW_RELU_EN defined SHALL make each psum_data lane max(acc[i],0) and saturate accumulation at +2^(PSUM_WIDTH-1)-1 instead of wrapping.
REQ-026 Macro PE_WINDOW_RELU_EN undefined SHALL output raw signed accumulators with wrap-around arithmetic.

Verification
REQ-027 WINDOW=6, K=3, w=[1,2,3], acts 1..8, num_windows=1 -> psum=[14,20,26,32,38,44], psum_valid 4 cycles after the 8th accept, then done.
REQ-028 num_windows=2, same setup, acts 9..14 in window 2 -> exactly 6 further accepts, first output 50.
REQ-029 K=5, w=[1,1,1,1,1], 10 acts all 1 -> all psums 5; COMPUTE lasts 5 cycles.
REQ-030 psum_ready held 0 for 3 cycles in OUT -> psum_data stable, act_ready=0 throughout.
REQ-031 flush after 4 accepts in FILL -> IDLE next cycle, no psum_valid, no done; num_windows=0 -> done 1 cycle after start.
REQ-032 w=[-1,0,0], acts all 5 -> psum=-5 with PE_WINDOW_RELU_EN undefined, 0 with it defined.
